imem_burst_ctrl: RTL and testbench

Synthesisable instruction-memory refill controller. It serves I-cache line misses from an internal word-addressed RAM. Each miss returns a burst of LINE_WORDS words, with programmable initial latency, inter-beat gap and burst ordering (linear or critical-word-first wrap). It sits between riscv_core's imem_word/word_ready/iram_address/i_miss interface and the backing instruction store, and replaces the fixed every-other-cycle refill model.

---
 rtl/imem_burst_ctrl_if.sv | 23 ++
 rtl/imem_burst_ctrl.sv | 127 ++++++++++++
 tb/tb_imem_burst_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_burst_ctrl_if.sv
// Refill bus between the core's instruction fetch side and the burst refill controller.
// The core is the master: it raises i_miss with miss_addr and consumes the returned words.
interface imem_burst_if #(
   parameter int ADDR_W = 10,
   parameter int WORD_W = 32
);
   logic              i_miss;
   logic [ADDR_W-1:0] miss_addr;
   logic              word_ready;
   logic [WORD_W-1:0] mem_word;
   logic              last_word;
   logic              busy;

   modport master (
      output i_miss, miss_addr,
      input  word_ready, mem_word, last_word, busy
   );

   modport slave (
      input  i_miss, miss_addr,
      output word_ready, mem_word, last_word, busy
   );
endinterface

// File: rtl/imem_burst_ctrl.sv
// Instruction-memory refill controller: serves a line miss as a burst of LINE_WORDS words
// from an internal RAM, with programmable first-word latency, beat gap and wrap ordering.
module imem_burst_ctrl #(
   parameter int WORD_W     = 32,
   parameter int ADDR_W     = 10,
   parameter int LINE_WORDS = 16,
   parameter int FIRST_LAT  = 2,
   parameter int BEAT_GAP   = 1,
   parameter int WRAP_MODE  = 0
) (
   input  logic              clk,
   input  logic              nrst,
   imem_burst_if.slave       bus,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [WORD_W-1:0] ld_data
);
   localparam int IDX_W   = $clog2(LINE_WORDS);
   localparam int CNT_MAX = (FIRST_LAT > BEAT_GAP) ? FIRST_LAT : BEAT_GAP;
   localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
   localparam logic [CNT_W-1:0]  LAT_LOAD  = CNT_W'(FIRST_LAT - 1);
   localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'((BEAT_GAP > 0) ? BEAT_GAP - 1 : 0);
   localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS - 1);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(LINE_WORDS - 1);

   typedef enum logic [2:0] {IDLE, LAT, BEAT, GAP, DONE} state_t;

   logic [WORD_W-1:0] ram [2**ADDR_W];

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [IDX_W-1:0]  idx_reg, idx_next;
   logic [ADDR_W-1:0] base_reg, base_next;
   logic              word_ready_reg, last_word_reg;
   logic [WORD_W-1:0] mem_word_reg;
   logic              fire;
   logic [ADDR_W-1:0] seq_addr, rd_addr;

   assign seq_addr = base_reg + ADDR_W'(idx_reg);

   generate
      if (WRAP_MODE != 0) begin : g_wrap
         assign rd_addr = (base_reg & ~LINE_MASK) | (seq_addr & LINE_MASK);
      end else begin : g_linear
         assign rd_addr = seq_addr;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (ld_we)
         ram[ld_addr] <= ld_data;
   end

   // fire marks the edge that registers a beat, so the strobe is visible while in BEAT
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      idx_next   = idx_reg;
      base_next  = base_reg;
      fire       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.i_miss) begin
               base_next  = bus.miss_addr;
               idx_next   = '0;
               cnt_next   = LAT_LOAD;
               state_next = LAT;
            end
         end
         LAT, GAP: begin
            if (!bus.i_miss) begin
               state_next = IDLE;
            end else if (cnt_reg == '0) begin
               fire       = 1'b1;
               state_next = BEAT;
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         BEAT: begin
            if (!bus.i_miss) begin
               state_next = IDLE;
            end else if (last_word_reg) begin
               state_next = DONE;
            end else if (BEAT_GAP == 0) begin
               fire = 1'b1;
            end else begin
               cnt_next   = GAP_LOAD;
               state_next = GAP;
            end
         end
         DONE: begin
            if (!bus.i_miss)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (fire)
         idx_next = idx_reg + 1'b1;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         idx_reg        <= '0;
         base_reg       <= '0;
         word_ready_reg <= 1'b0;
         last_word_reg  <= 1'b0;
         mem_word_reg   <= '0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         idx_reg        <= idx_next;
         base_reg       <= base_next;
         word_ready_reg <= fire;
         last_word_reg  <= fire && (idx_reg == LAST_IDX);
         if (fire)
            mem_word_reg <= ram[rd_addr];
      end
   end

   assign bus.word_ready = word_ready_reg;
   assign bus.last_word  = last_word_reg;
   assign bus.mem_word   = mem_word_reg;
   assign bus.busy       = (state_reg != IDLE);
endmodule

// File: tb/tb_imem_burst_ctrl.sv
// Bench for imem_burst_ctrl: three instances with different latency/gap/wrap settings share
// one RAM load port; a scoreboard queue holds the expected word, last flag and cycle per beat.
module tb_imem_burst_ctrl;
   typedef struct {
      logic [31:0] data;
      logic        last;
      int          cyc;
   } exp_t;

   logic        clk;
   logic        nrst;
   logic        ld_we;
   logic [9:0]  ld_addr;
   logic [31:0] ld_data;
   logic [2:0]  miss_v;
   logic [9:0]  miss_addr_v [3];
   logic [2:0]  wr_a, last_a, busy_a;
   logic [31:0] word_a [3];

   int          cyc;
   int          checks;
   int          passes;
   logic [31:0] ram_m [1024];
   exp_t        sbq [$];

   int fl_p   [3] = '{2, 2, 1};
   int gap_p  [3] = '{1, 1, 0};
   int lw_p   [3] = '{16, 4, 4};
   int wrap_p [3] = '{0, 1, 0};

   imem_burst_if #(.ADDR_W(10), .WORD_W(32)) bus0 ();
   imem_burst_if #(.ADDR_W(10), .WORD_W(32)) bus1 ();
   imem_burst_if #(.ADDR_W(10), .WORD_W(32)) bus2 ();

   imem_burst_ctrl dut0 (
      .clk(clk), .nrst(nrst), .bus(bus0),
      .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
   );
   imem_burst_ctrl #(.LINE_WORDS(4), .WRAP_MODE(1)) dut1 (
      .clk(clk), .nrst(nrst), .bus(bus1),
      .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
   );
   imem_burst_ctrl #(.LINE_WORDS(4), .FIRST_LAT(1), .BEAT_GAP(0)) dut2 (
      .clk(clk), .nrst(nrst), .bus(bus2),
      .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
   );

   assign bus0.i_miss = miss_v[0];
   assign bus1.i_miss = miss_v[1];
   assign bus2.i_miss = miss_v[2];
   assign bus0.miss_addr = miss_addr_v[0];
   assign bus1.miss_addr = miss_addr_v[1];
   assign bus2.miss_addr = miss_addr_v[2];
   assign wr_a   = {bus2.word_ready, bus1.word_ready, bus0.word_ready};
   assign last_a = {bus2.last_word, bus1.last_word, bus0.last_word};
   assign busy_a = {bus2.busy, bus1.busy, bus0.busy};
   assign word_a[0] = bus0.mem_word;
   assign word_a[1] = bus1.mem_word;
   assign word_a[2] = bus2.mem_word;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic test_reset();
      nrst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (wr_a[d] !== 1'b0) $display("FAIL reset_word_ready dut%0d got %b want 0", d, wr_a[d]);
         else passes++;
         checks++;
         if (last_a[d] !== 1'b0) $display("FAIL reset_last_word dut%0d got %b want 0", d, last_a[d]);
         else passes++;
         checks++;
         if (busy_a[d] !== 1'b0) $display("FAIL reset_busy dut%0d got %b want 0", d, busy_a[d]);
         else passes++;
         checks++;
         if (word_a[d] !== 32'h0) $display("FAIL reset_mem_word dut%0d got %h want 0", d, word_a[d]);
         else passes++;
      end
      @(negedge clk);
      nrst = 1'b1;
      $display("reset: outputs of 3 instances checked");
   endtask

   task automatic load_ram();
      for (int i = 0; i < 1024; i++) begin
         @(negedge clk);
         ld_we   = 1'b1;
         ld_addr = 10'(i);
         ld_data = 32'(i);
         ram_m[i] = 32'(i);
      end
      @(negedge clk);
      ld_we = 1'b0;
      $display("load: 1024 words written");
   endtask

   // One refill on instance d. abort_after>0 drops i_miss after that many strobes;
   // wr_hit writes the first beat's address on the same edge that reads it.
   task automatic run_burst(input int d, input logic [9:0] addr, input int abort_after,
                            input bit wr_hit, input string name);
      int          k, nstrobe, drop_cyc, extra, lw, bad;
      logic [9:0]  a, mask;
      logic [31:0] new_data;
      exp_t        e;
      lw       = lw_p[d];
      mask     = 10'(lw - 1);
      new_data = 32'hDEAD_0000 | 32'(addr);
      @(negedge clk);
      miss_addr_v[d] = addr;
      miss_v[d]      = 1'b1;
      k              = cyc + 1;
      for (int n = 0; n < lw; n++) begin
         if (wrap_p[d] != 0) a = (addr & ~mask) | ((addr + 10'(n)) & mask);
         else                a = addr + 10'(n);
         e.data = ram_m[a];
         e.last = (n == lw - 1);
         e.cyc  = k + fl_p[d] + n * (gap_p[d] + 1);
         sbq.push_back(e);
      end
      nstrobe  = 0;
      drop_cyc = 0;
      for (int t = 0; t < 200 && sbq.size() > 0; t++) begin
         @(negedge clk);
         if (last_a[d] && !wr_a[d]) begin
            checks++;
            $display("FAIL %s last_without_strobe dut%0d at cycle %0d", name, d, cyc);
         end
         if (wr_a[d]) begin
            e = sbq.pop_front();
            nstrobe++;
            checks++;
            if (word_a[d] !== e.data)
               $display("FAIL %s beat%0d_data got %h want %h", name, nstrobe - 1, word_a[d], e.data);
            else passes++;
            checks++;
            if (last_a[d] !== e.last)
               $display("FAIL %s beat%0d_last got %b want %b", name, nstrobe - 1, last_a[d], e.last);
            else passes++;
            checks++;
            if (cyc != e.cyc)
               $display("FAIL %s beat%0d_cycle got %0d want %0d", name, nstrobe - 1, cyc, e.cyc);
            else passes++;
         end
         if (wr_hit) begin
            if (cyc == k) begin
               ld_we   = 1'b1;
               ld_addr = addr;
               ld_data = new_data;
            end else if (cyc == k + 1) begin
               ld_we      = 1'b0;
               ram_m[addr] = new_data;
            end
         end
         if (abort_after > 0 && nstrobe == abort_after) begin
            miss_v[d] = 1'b0;
            drop_cyc  = cyc;
            break;
         end
      end
      ld_we = 1'b0;
      if (abort_after > 0) begin
         extra = 0;
         for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            if (wr_a[d]) begin
               extra++;
               if (sbq.size() > 0) begin
                  e = sbq.pop_front();
                  checks++;
                  if (word_a[d] !== e.data)
                     $display("FAIL %s post_abort_data got %h want %h", name, word_a[d], e.data);
                  else passes++;
               end
            end
            if (t == 1) begin
               checks++;
               if (busy_a[d] !== 1'b0)
                  $display("FAIL %s abort_busy got %b want 0 (cycle %0d)", name, busy_a[d], cyc);
               else passes++;
            end
         end
         checks++;
         if (extra > 1 || nstrobe != abort_after)
            $display("FAIL %s abort_strobes got %0d+%0d want %0d+<=1", name, nstrobe, extra, abort_after);
         else passes++;
         sbq.delete();
         $display("burst %s: dut%0d addr %h aborted after %0d strobes at cycle %0d",
                  name, d, addr, nstrobe, drop_cyc);
      end else begin
         checks++;
         if (sbq.size() != 0)
            $display("FAIL %s timeout got %0d strobes want %0d", name, nstrobe, lw);
         else passes++;
         sbq.delete();
         bad = 0;
         repeat (6) begin
            @(negedge clk);
            if (wr_a[d] || !busy_a[d]) bad++;
         end
         checks++;
         if (bad != 0) $display("FAIL %s hold_no_retrigger got %0d bad cycles want 0", name, bad);
         else passes++;
         miss_v[d] = 1'b0;
         @(negedge clk);
         checks++;
         if (busy_a[d] !== 1'b0) $display("FAIL %s release_busy got %b want 0", name, busy_a[d]);
         else passes++;
         $display("burst %s: dut%0d addr %h %0d strobes", name, d, addr, nstrobe);
      end
   endtask

   task automatic test_linear_burst();
      run_burst(0, 10'h005, 0, 1'b0, "linear");
   endtask

   task automatic test_wrap();
      run_burst(1, 10'h00E, 0, 1'b0, "wrap");
   endtask

   task automatic test_addr_rollover();
      run_burst(2, 10'h3FE, 0, 1'b0, "rollover");
   endtask

   task automatic test_back_to_back();
      run_burst(2, 10'h020, 0, 1'b0, "back_to_back");
   endtask

   task automatic test_abort();
      run_burst(0, 10'h040, 3, 1'b0, "abort");
      run_burst(0, 10'h080, 0, 1'b0, "after_abort");
   endtask

   task automatic test_reset_mid_gap();
      bit seen;
      @(negedge clk);
      miss_addr_v[0] = 10'h200;
      miss_v[0]      = 1'b1;
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
         @(negedge clk);
         if (wr_a[0]) seen = 1'b1;
      end
      checks++;
      if (!seen) $display("FAIL reset_gap first_strobe got none want 1");
      else passes++;
      @(posedge clk);
      #2;
      checks++;
      if (busy_a[0] !== 1'b1 || wr_a[0] !== 1'b0)
         $display("FAIL reset_gap in_gap got busy=%b wr=%b want busy=1 wr=0", busy_a[0], wr_a[0]);
      else passes++;
      nrst = 1'b0;
      #1;
      checks++;
      if (busy_a[0] !== 1'b0) $display("FAIL reset_gap busy got %b want 0", busy_a[0]);
      else passes++;
      checks++;
      if (wr_a[0] !== 1'b0 || last_a[0] !== 1'b0)
         $display("FAIL reset_gap strobes got wr=%b last=%b want 0", wr_a[0], last_a[0]);
      else passes++;
      checks++;
      if (word_a[0] !== 32'h0) $display("FAIL reset_gap mem_word got %h want 0", word_a[0]);
      else passes++;
      miss_v[0] = 1'b0;
      @(negedge clk);
      nrst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (busy_a[0] !== 1'b0) $display("FAIL reset_gap post_release_busy got %b want 0", busy_a[0]);
      else passes++;
      $display("reset_mid_gap: dut0 addr 200 reset during gap");
   endtask

   task automatic test_write_collision();
      run_burst(2, 10'h100, 0, 1'b1, "collide");
      run_burst(2, 10'h100, 0, 1'b0, "after_write");
   endtask

   initial begin
      cyc     = 0;
      checks  = 0;
      passes  = 0;
      nrst    = 1'b0;
      ld_we   = 1'b0;
      ld_addr = '0;
      ld_data = '0;
      miss_v  = '0;
      for (int d = 0; d < 3; d++) miss_addr_v[d] = '0;
      test_reset();
      load_ram();
      test_linear_burst();
      test_wrap();
      test_addr_rollover();
      test_back_to_back();
      test_abort();
      test_reset_mid_gap();
      run_burst(0, 10'h005, 0, 1'b0, "post_reset");
      test_write_collision();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
